kamikaze_mem_arbiter: RTL and testbench

//  Shares one 32-bit memory port between instruction fetch (IF) and load/store (LS).

---
 rtl/kamikaze_mem_arbiter.sv | 128 ++++++++++++
 tb/tb_kamikaze_mem_arbiter.sv | 207 ++++++++++++++++++++
 2 files changed

// File: rtl/kamikaze_mem_arbiter.sv
// Shares one 32-bit memory port between instruction fetch and load/store, with flush-drop and timeout.
// Optional round-robin arbitration when KMKZ_ARB_RR_EN is defined (default: fixed LS-over-IF priority).
module kamikaze_mem_arbiter #(
   parameter int unsigned TIMEOUT_CYCLES = 255,
   parameter int unsigned TO_W           = 16
) (
   input  logic        clk_i,
   input  logic        rst_i,
   input  logic        flush_i,
   input  logic        if_req_i,
   input  logic [31:0] if_addr_i,
   output logic [31:0] if_data_o,
   output logic        if_ready_o,
   output logic        if_err_o,
   input  logic        ls_req_i,
   input  logic [31:0] ls_addr_i,
   input  logic [31:0] ls_wdata_i,
   input  logic        ls_we_i,
   input  logic [3:0]  ls_be_i,
   output logic [31:0] ls_rdata_o,
   output logic        ls_ready_o,
   output logic        ls_err_o,
   output logic        mem_req_o,
   output logic [31:0] mem_addr_o,
   output logic [31:0] mem_wdata_o,
   output logic        mem_we_o,
   output logic [3:0]  mem_be_o,
   input  logic [31:0] mem_rdata_i,
   input  logic        mem_ack_i
);

   typedef enum logic [1:0] {IDLE, FETCH, LSU, DROP} state_t;

   localparam logic [TO_W-1:0] TO_LAST =
      (TIMEOUT_CYCLES == 0) ? '0 : TO_W'(TIMEOUT_CYCLES - 1);

   state_t          state;
   logic [TO_W-1:0] cnt;
   logic            if_eff;
   logic            grant_ls;
   logic            grant_if;
   logic            to_hit;
   logic            fetch_live;
   logic            ls_live;

   // A flush in IDLE cancels the fetch request for that cycle only.
   assign if_eff = if_req_i & ~flush_i;
   assign to_hit = (TIMEOUT_CYCLES != 0) && (cnt == TO_LAST) && !mem_ack_i;

`ifdef KMKZ_ARB_RR_EN
   logic last_ls;

   // Under contention the port granted last loses; a lone requester always wins.
   assign grant_ls = ls_req_i & (~if_eff | ~last_ls);

   always_ff @(posedge clk_i or negedge rst_i) begin
      if (!rst_i) begin
         last_ls <= 1'b0;
      end else if (state == IDLE && (grant_ls || if_eff)) begin
         last_ls <= grant_ls;
      end
   end
`else
   assign grant_ls = ls_req_i;
`endif

   assign grant_if = if_eff & ~grant_ls;

   always_ff @(posedge clk_i or negedge rst_i) begin
      if (!rst_i) begin
         state       <= IDLE;
         cnt         <= '0;
         mem_req_o   <= 1'b0;
         mem_addr_o  <= '0;
         mem_wdata_o <= '0;
         mem_we_o    <= 1'b0;
         mem_be_o    <= '0;
      end else begin
         case (state)
            IDLE: begin
               cnt <= '0;
               if (grant_ls) begin
                  state       <= LSU;
                  mem_req_o   <= 1'b1;
                  mem_addr_o  <= ls_addr_i;
                  mem_wdata_o <= ls_wdata_i;
                  mem_we_o    <= ls_we_i;
                  mem_be_o    <= ls_be_i;
               end else if (grant_if) begin
                  state       <= FETCH;
                  mem_req_o   <= 1'b1;
                  mem_addr_o  <= if_addr_i;
                  mem_wdata_o <= '0;
                  mem_we_o    <= 1'b0;
                  mem_be_o    <= 4'hF;
               end
            end
            FETCH, LSU, DROP: begin
               if (mem_ack_i || to_hit) begin
                  state     <= IDLE;
                  mem_req_o <= 1'b0;
                  cnt       <= '0;
               end else if (state == FETCH && flush_i) begin
                  // Memory cannot abort, so keep the request up and swallow the response.
                  state <= DROP;
                  cnt   <= '0;
               end else if (cnt != '1) begin
                  cnt <= cnt + 1'b1;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

   // Completion is reported combinationally in the ack (or timeout) cycle.
   assign fetch_live = (state == FETCH) && !flush_i;
   assign ls_live    = (state == LSU);

   assign if_ready_o = fetch_live && (mem_ack_i || to_hit);
   assign if_err_o   = fetch_live && to_hit;
   assign if_data_o  = (fetch_live && mem_ack_i) ? mem_rdata_i : '0;

   assign ls_ready_o = ls_live && (mem_ack_i || to_hit);
   assign ls_err_o   = ls_live && to_hit;
   assign ls_rdata_o = (ls_live && mem_ack_i) ? mem_rdata_i : '0;

endmodule

// File: tb/tb_kamikaze_mem_arbiter.sv
// Directed bench for kamikaze_mem_arbiter: fetch, arbitration, store, flush, timeout and reset abort.
// Expected arbitration order follows KMKZ_ARB_RR_EN when that macro is defined.
module tb_kamikaze_mem_arbiter;

   logic        clk_i;
   logic        rst_i;
   logic        flush_i;
   logic        if_req_i;
   logic [31:0] if_addr_i;
   logic [31:0] if_data_o;
   logic        if_ready_o;
   logic        if_err_o;
   logic        ls_req_i;
   logic [31:0] ls_addr_i;
   logic [31:0] ls_wdata_i;
   logic        ls_we_i;
   logic [3:0]  ls_be_i;
   logic [31:0] ls_rdata_o;
   logic        ls_ready_o;
   logic        ls_err_o;
   logic        mem_req_o;
   logic [31:0] mem_addr_o;
   logic [31:0] mem_wdata_o;
   logic        mem_we_o;
   logic [3:0]  mem_be_o;
   logic [31:0] mem_rdata_i;
   logic        mem_ack_i;

   int n_cmp = 0;
   int n_bad = 0;

   kamikaze_mem_arbiter #(.TIMEOUT_CYCLES(4), .TO_W(16)) dut (
      .clk_i(clk_i), .rst_i(rst_i), .flush_i(flush_i),
      .if_req_i(if_req_i), .if_addr_i(if_addr_i), .if_data_o(if_data_o),
      .if_ready_o(if_ready_o), .if_err_o(if_err_o),
      .ls_req_i(ls_req_i), .ls_addr_i(ls_addr_i), .ls_wdata_i(ls_wdata_i),
      .ls_we_i(ls_we_i), .ls_be_i(ls_be_i), .ls_rdata_o(ls_rdata_o),
      .ls_ready_o(ls_ready_o), .ls_err_o(ls_err_o),
      .mem_req_o(mem_req_o), .mem_addr_o(mem_addr_o), .mem_wdata_o(mem_wdata_o),
      .mem_we_o(mem_we_o), .mem_be_o(mem_be_o), .mem_rdata_i(mem_rdata_i),
      .mem_ack_i(mem_ack_i)
   );

   initial clk_i = 1'b0;
   always #5 clk_i = ~clk_i;

   task automatic test_reset();
      @(negedge clk_i); #1;
      n_cmp++; if (mem_req_o !== 1'b0) begin n_bad++; $display("FAIL rst_req got %0h want 0", mem_req_o); end
      n_cmp++; if (mem_addr_o !== 32'h0) begin n_bad++; $display("FAIL rst_addr got %0h want 0", mem_addr_o); end
      n_cmp++; if (mem_be_o !== 4'h0 || mem_we_o !== 1'b0) begin n_bad++; $display("FAIL rst_be_we got %0h/%0h want 0/0", mem_be_o, mem_we_o); end
      n_cmp++; if ({if_ready_o, if_err_o, ls_ready_o, ls_err_o} !== 4'b0) begin n_bad++; $display("FAIL rst_ready got %b want 0000", {if_ready_o, if_err_o, ls_ready_o, ls_err_o}); end
      @(negedge clk_i);
      rst_i = 1'b1;
      $display("reset released");
   endtask

   task automatic test_fetch();
      @(negedge clk_i);
      if_req_i = 1'b1; if_addr_i = 32'h100; #1;
      n_cmp++; if (mem_req_o !== 1'b0) begin n_bad++; $display("FAIL fetch_pre_req got %0h want 0", mem_req_o); end
      @(negedge clk_i); #1;
      n_cmp++; if (mem_req_o !== 1'b1 || mem_addr_o !== 32'h100) begin n_bad++; $display("FAIL fetch_req got %0h@%0h want 1@100", mem_req_o, mem_addr_o); end
      n_cmp++; if (mem_be_o !== 4'hF || mem_we_o !== 1'b0) begin n_bad++; $display("FAIL fetch_be_we got %0h/%0h want f/0", mem_be_o, mem_we_o); end
      n_cmp++; if (if_ready_o !== 1'b0) begin n_bad++; $display("FAIL fetch_early_ready got %0h want 0", if_ready_o); end
      @(negedge clk_i); #1;
      n_cmp++; if (if_ready_o !== 1'b0 || mem_req_o !== 1'b1) begin n_bad++; $display("FAIL fetch_wait got rdy=%0h req=%0h want 0/1", if_ready_o, mem_req_o); end
      @(negedge clk_i);
      mem_ack_i = 1'b1; mem_rdata_i = 32'hCAFE_0001; #1;
      n_cmp++; if (if_ready_o !== 1'b1 || if_data_o !== 32'hCAFE_0001) begin n_bad++; $display("FAIL fetch_ack got rdy=%0h data=%0h want 1/cafe0001", if_ready_o, if_data_o); end
      n_cmp++; if (ls_ready_o !== 1'b0 || if_err_o !== 1'b0) begin n_bad++; $display("FAIL fetch_other got ls=%0h err=%0h want 0/0", ls_ready_o, if_err_o); end
      @(negedge clk_i);
      mem_ack_i = 1'b0; if_req_i = 1'b0; #1;
      n_cmp++; if (mem_req_o !== 1'b0 || if_ready_o !== 1'b0) begin n_bad++; $display("FAIL fetch_after got req=%0h rdy=%0h want 0/0", mem_req_o, if_ready_o); end
      $display("fetch @100 done");
   endtask

   task automatic test_arbitration();
      logic [5:0] exp_ls;
`ifdef KMKZ_ARB_RR_EN
      exp_ls = 6'b010101;
`else
      exp_ls = 6'b110101;
`endif
      ls_addr_i = 32'h300; ls_we_i = 1'b0; ls_be_i = 4'hF; if_addr_i = 32'h400;
      for (int k = 0; k < 6; k++) begin
         @(negedge clk_i);
         mem_ack_i = 1'b0; if_req_i = 1'b1;
         ls_req_i = (k == 1 || k == 3) ? 1'b0 : 1'b1; #1;
         n_cmp++; if (mem_req_o !== 1'b0) begin n_bad++; $display("FAIL arb_idle%0d got %0h want 0", k, mem_req_o); end
         @(negedge clk_i);
         ls_req_i = 1'b1; mem_ack_i = 1'b1; mem_rdata_i = 32'h1000 + k; #1;
         n_cmp++; if (mem_addr_o !== (exp_ls[k] ? 32'h300 : 32'h400)) begin n_bad++; $display("FAIL arb_owner%0d got %0h want %0h", k, mem_addr_o, exp_ls[k] ? 32'h300 : 32'h400); end
         n_cmp++; if (ls_ready_o !== exp_ls[k] || if_ready_o !== !exp_ls[k]) begin n_bad++; $display("FAIL arb_ready%0d got ls=%0h if=%0h want ls=%0h", k, ls_ready_o, if_ready_o, exp_ls[k]); end
         n_cmp++; if ((exp_ls[k] ? ls_rdata_o : if_data_o) !== 32'h1000 + k) begin n_bad++; $display("FAIL arb_data%0d got %0h want %0h", k, exp_ls[k] ? ls_rdata_o : if_data_o, 32'h1000 + k); end
         $display("arb access %0d owner=%s", k, exp_ls[k] ? "LS" : "IF");
      end
      @(negedge clk_i);
      mem_ack_i = 1'b0; if_req_i = 1'b0; ls_req_i = 1'b0;
   endtask

   task automatic test_store();
      @(negedge clk_i);
      ls_req_i = 1'b1; ls_addr_i = 32'h200; ls_wdata_i = 32'hDEAD_BEEF; ls_we_i = 1'b1; ls_be_i = 4'b0011;
      @(negedge clk_i); #1;
      n_cmp++; if (mem_req_o !== 1'b1 || mem_addr_o !== 32'h200) begin n_bad++; $display("FAIL st_req got %0h@%0h want 1@200", mem_req_o, mem_addr_o); end
      n_cmp++; if (mem_we_o !== 1'b1 || mem_wdata_o !== 32'hDEAD_BEEF || mem_be_o !== 4'h3) begin n_bad++; $display("FAIL st_fields got we=%0h wd=%0h be=%0h want 1/deadbeef/3", mem_we_o, mem_wdata_o, mem_be_o); end
      @(negedge clk_i);
      mem_ack_i = 1'b1; #1;
      n_cmp++; if (ls_ready_o !== 1'b1 || if_ready_o !== 1'b0 || ls_err_o !== 1'b0) begin n_bad++; $display("FAIL st_ack got ls=%0h if=%0h err=%0h want 1/0/0", ls_ready_o, if_ready_o, ls_err_o); end
      @(negedge clk_i);
      mem_ack_i = 1'b0; ls_req_i = 1'b0; ls_we_i = 1'b0; #1;
      n_cmp++; if (mem_req_o !== 1'b0 || ls_ready_o !== 1'b0) begin n_bad++; $display("FAIL st_after got req=%0h rdy=%0h want 0/0", mem_req_o, ls_ready_o); end
      $display("store deadbeef @200 be=3 done");
   endtask

   task automatic test_flush_drop();
      @(negedge clk_i);
      if_req_i = 1'b1; if_addr_i = 32'h500;
      @(negedge clk_i);
      flush_i = 1'b1; #1;
      n_cmp++; if (mem_req_o !== 1'b1 || if_ready_o !== 1'b0) begin n_bad++; $display("FAIL fl_grant got req=%0h rdy=%0h want 1/0", mem_req_o, if_ready_o); end
      @(negedge clk_i);
      flush_i = 1'b0; if_req_i = 1'b0; #1;
      n_cmp++; if (mem_req_o !== 1'b1 || mem_addr_o !== 32'h500) begin n_bad++; $display("FAIL fl_drop_hold got %0h@%0h want 1@500", mem_req_o, mem_addr_o); end
      @(negedge clk_i); #1;
      n_cmp++; if (mem_req_o !== 1'b1 || if_ready_o !== 1'b0) begin n_bad++; $display("FAIL fl_drop_wait got req=%0h rdy=%0h want 1/0", mem_req_o, if_ready_o); end
      @(negedge clk_i);
      mem_ack_i = 1'b1; mem_rdata_i = 32'h5555_AAAA;
      ls_req_i = 1'b1; ls_addr_i = 32'h600; ls_we_i = 1'b0; ls_be_i = 4'hF; #1;
      n_cmp++; if (if_ready_o !== 1'b0 || ls_ready_o !== 1'b0) begin n_bad++; $display("FAIL fl_drop_ack got if=%0h ls=%0h want 0/0", if_ready_o, ls_ready_o); end
      @(negedge clk_i);
      mem_ack_i = 1'b0; #1;
      n_cmp++; if (mem_req_o !== 1'b0) begin n_bad++; $display("FAIL fl_idle got %0h want 0", mem_req_o); end
      @(negedge clk_i);
      mem_ack_i = 1'b1; mem_rdata_i = 32'h6666_0000; #1;
      n_cmp++; if (mem_addr_o !== 32'h600 || ls_ready_o !== 1'b1 || ls_rdata_o !== 32'h6666_0000) begin n_bad++; $display("FAIL fl_next got %0h rdy=%0h d=%0h want 600/1/66660000", mem_addr_o, ls_ready_o, ls_rdata_o); end
      @(negedge clk_i);
      mem_ack_i = 1'b0; ls_req_i = 1'b0;
      $display("flush drop of fetch @500 done");
   endtask

   task automatic test_flush_edges();
      @(negedge clk_i);
      if_req_i = 1'b1; if_addr_i = 32'h900; flush_i = 1'b1;
      @(negedge clk_i);
      flush_i = 1'b0; #1;
      n_cmp++; if (mem_req_o !== 1'b0) begin n_bad++; $display("FAIL fe_idle_mask got %0h want 0", mem_req_o); end
      @(negedge clk_i);
      flush_i = 1'b1; mem_ack_i = 1'b1; mem_rdata_i = 32'h9999_0000; #1;
      n_cmp++; if (mem_addr_o !== 32'h900 || if_ready_o !== 1'b0) begin n_bad++; $display("FAIL fe_flush_ack got %0h rdy=%0h want 900/0", mem_addr_o, if_ready_o); end
      @(negedge clk_i);
      flush_i = 1'b0; mem_ack_i = 1'b0; if_req_i = 1'b0; #1;
      n_cmp++; if (mem_req_o !== 1'b0 || if_ready_o !== 1'b0) begin n_bad++; $display("FAIL fe_after got req=%0h rdy=%0h want 0/0", mem_req_o, if_ready_o); end
      $display("flush in idle and with ack done");
   endtask

   task automatic test_timeout();
      @(negedge clk_i);
      ls_req_i = 1'b1; ls_addr_i = 32'h700; ls_we_i = 1'b0; ls_be_i = 4'hF; mem_rdata_i = 32'hBAD0_BAD0;
      for (int c = 0; c < 4; c++) begin
         @(negedge clk_i); #1;
         n_cmp++; if (mem_req_o !== 1'b1) begin n_bad++; $display("FAIL to_req%0d got %0h want 1", c, mem_req_o); end
         n_cmp++; if (ls_ready_o !== (c == 3) || ls_err_o !== (c == 3)) begin n_bad++; $display("FAIL to_pulse%0d got rdy=%0h err=%0h want %0h", c, ls_ready_o, ls_err_o, c == 3); end
      end
      n_cmp++; if (ls_rdata_o !== 32'h0) begin n_bad++; $display("FAIL to_data got %0h want 0", ls_rdata_o); end
      @(negedge clk_i);
      ls_req_i = 1'b0; #1;
      n_cmp++; if (mem_req_o !== 1'b0 || ls_ready_o !== 1'b0 || ls_err_o !== 1'b0) begin n_bad++; $display("FAIL to_after got req=%0h rdy=%0h err=%0h want 0/0/0", mem_req_o, ls_ready_o, ls_err_o); end
      $display("timeout of load @700 done");
   endtask

   task automatic test_reset_mid();
      @(negedge clk_i);
      if_req_i = 1'b1; if_addr_i = 32'h800;
      @(negedge clk_i); #1;
      n_cmp++; if (mem_req_o !== 1'b1 || mem_addr_o !== 32'h800) begin n_bad++; $display("FAIL rm_grant got %0h@%0h want 1@800", mem_req_o, mem_addr_o); end
      #1 rst_i = 1'b0; #1;
      n_cmp++; if (mem_req_o !== 1'b0 || mem_addr_o !== 32'h0 || mem_be_o !== 4'h0) begin n_bad++; $display("FAIL rm_abort got req=%0h a=%0h be=%0h want 0/0/0", mem_req_o, mem_addr_o, mem_be_o); end
      n_cmp++; if (if_ready_o !== 1'b0) begin n_bad++; $display("FAIL rm_ready got %0h want 0", if_ready_o); end
      @(negedge clk_i);
      rst_i = 1'b1; if_req_i = 1'b0; mem_ack_i = 1'b1; #1;
      n_cmp++; if (if_ready_o !== 1'b0 || ls_ready_o !== 1'b0) begin n_bad++; $display("FAIL rm_late_ack got if=%0h ls=%0h want 0/0", if_ready_o, ls_ready_o); end
      @(negedge clk_i);
      mem_ack_i = 1'b0; #1;
      n_cmp++; if (mem_req_o !== 1'b0) begin n_bad++; $display("FAIL rm_after got %0h want 0", mem_req_o); end
      $display("reset mid-fetch done");
   endtask

   initial begin
      rst_i = 1'b0; flush_i = 1'b0;
      if_req_i = 1'b0; if_addr_i = '0;
      ls_req_i = 1'b0; ls_addr_i = '0; ls_wdata_i = '0; ls_we_i = 1'b0; ls_be_i = '0;
      mem_rdata_i = '0; mem_ack_i = 1'b0;
      test_reset();
      test_fetch();
      test_arbitration();
      test_store();
      test_flush_drop();
      test_flush_edges();
      test_timeout();
      test_reset_mid();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
